// File: rtl/debug_master_if.sv
// Host-side command/response handshake for the debug master.
// The host drives commands and accepts responses; the debug master is the slave.
interface debug_master_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [7:0] CMD_ARG;
    logic [7:0] CMD_DATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_DATA;
    logic       RSP_ERR;

    modport master (
        output CMD_VALID, CMD_OP, CMD_ARG, CMD_DATA, RSP_READY,
        input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_ARG, CMD_DATA, RSP_READY,
        output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

// File: rtl/debug_master.sv
// Debug-port master: attaches to the core via DEBUG_REQUEST/ACK and sequences
// the D_* control word to read/write RAM and registers, one response per command.
module debug_master #(
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       CLK,
    input  logic       RESETn,
    debug_master_if.slave host,
    output logic       ATTACHED,
    output logic       DEBUG_REQUEST,
    input  logic       DEBUG_ACK,
    output logic [7:0] DEBUG_DATA,
    output logic       D_CLR, D_HLT, D_CE, D_SU, D_RI,
    output logic       D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn,
    output logic       D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn,
    input  logic [7:0] BUS
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_READY, S_PH1, S_PH2, S_RSP, S_REL
    } state_t;

    typedef struct packed {
        logic clr, hlt, ce, su, ri;
        logic ain, bin, oin, iin, jn, fin, min;
        logic don, aon, bon, ion, con, eon, ron, non;
    } ctl_t;

    localparam logic [2:0] OP_ATTACH = 3'd0;
    localparam logic [2:0] OP_DETACH = 3'd1;
    localparam logic [2:0] OP_MEM_WR = 3'd2;
    localparam logic [2:0] OP_MEM_RD = 3'd3;
    localparam logic [2:0] OP_REG_WR = 3'd4;
    localparam logic [2:0] OP_REG_RD = 3'd5;
    localparam logic [2:0] OP_CLEAR  = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam ctl_t       CTL_IDLE  = 20'h07FFF;
    localparam logic [7:0] ADDR_MASK = 8'((9'd1 << ADDR_W) - 9'd1);
    localparam int         CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       arg_q, arg_d, dat_q, dat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, att_q, att_d, err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    ctl_t             ctl_q, ctl_d;
    logic [7:0]       ddata_q, ddata_d;
    logic             cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic             accept;

    function automatic logic sel_ok(input logic [2:0] op, input logic [2:0] sel);
        case (op)
            OP_REG_WR: return sel <= 3'd4;
            OP_REG_RD: return sel <= 3'd5;
            default:   return 1'b1;
        endcase
    endfunction

    assign accept = host.CMD_VALID && cmd_ready_q;

    // State register: control and registered outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            att_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ctl_q       <= CTL_IDLE;
            ddata_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            att_q       <= att_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ctl_q       <= ctl_d;
            ddata_q     <= ddata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Command fields carry no control meaning, so they are not reset
    always_ff @(posedge CLK) begin
        op_q  <= op_d;
        arg_q <= arg_d;
        dat_q <= dat_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        att_d   = att_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (accept) begin
            op_d  = host.CMD_OP;
            arg_d = host.CMD_ARG;
            dat_d = host.CMD_DATA;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (host.CMD_OP == OP_ATTACH) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RSP;
                        err_d   = (host.CMD_OP != OP_DETACH);
                        rdata_d = '0;
                    end
                end
            end
            S_READY: begin
                if (accept) begin
                    case (host.CMD_OP)
                        OP_ATTACH: begin
                            state_d = S_RSP;
                            err_d   = 1'b0;
                            rdata_d = '0;
                        end
                        OP_DETACH: begin
                            state_d = S_REL;
                            req_d   = 1'b0;
                            cnt_d   = '0;
                        end
                        OP_RSVD: begin
                            state_d = S_RSP;
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end
                        default: begin
                            if (sel_ok(host.CMD_OP, host.CMD_ARG[2:0])) begin
                                state_d = S_PH1;
                            end else begin
                                state_d = S_RSP;
                                err_d   = 1'b1;
                                rdata_d = '0;
                            end
                        end
                    endcase
                end else if (!DEBUG_ACK) begin
                    // Core left debug mode on its own: silently fall back to IDLE
                    state_d = S_IDLE;
                    att_d   = 1'b0;
                    req_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (DEBUG_ACK) begin
                    state_d = S_RSP;
                    att_d   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RSP;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PH1, S_PH2: begin
                if (!DEBUG_ACK) begin
                    state_d = S_RSP;
                    att_d   = 1'b0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (state_q == S_PH1 && (op_q == OP_MEM_WR || op_q == OP_MEM_RD)) begin
                    state_d = S_PH2;
                end else begin
                    state_d = S_RSP;
                    err_d   = 1'b0;
                    rdata_d = (op_q == OP_REG_RD || op_q == OP_MEM_RD) ? BUS : 8'h00;
                end
            end
            S_REL: begin
                if (!DEBUG_ACK || cnt_q == CNT_LAST) begin
                    state_d = S_RSP;
                    att_d   = 1'b0;
                    err_d   = DEBUG_ACK;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                if (host.RSP_READY) begin
                    state_d = att_q ? S_READY : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, registered at the same edge
    always_comb begin
        ctl_d       = CTL_IDLE;
        ddata_d     = '0;
        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_READY);
        rsp_valid_d = (state_d == S_RSP);
        case (state_d)
            S_PH1: begin
                case (op_d)
                    OP_MEM_WR, OP_MEM_RD: begin
                        ddata_d   = arg_d & ADDR_MASK;
                        ctl_d.don = 1'b0;
                        ctl_d.min = 1'b0;
                    end
                    OP_REG_WR: begin
                        ddata_d   = dat_d;
                        ctl_d.don = 1'b0;
                        case (arg_d[2:0])
                            3'd0:    ctl_d.ain = 1'b0;
                            3'd1:    ctl_d.bin = 1'b0;
                            3'd2:    ctl_d.oin = 1'b0;
                            3'd3:    ctl_d.iin = 1'b0;
                            3'd4:    ctl_d.jn  = 1'b0;
                            default: ;
                        endcase
                    end
                    OP_REG_RD: begin
                        case (arg_d[2:0])
                            3'd0:    ctl_d.aon = 1'b0;
                            3'd1:    ctl_d.bon = 1'b0;
                            3'd2:    ctl_d.ion = 1'b0;
                            3'd3:    ctl_d.con = 1'b0;
                            3'd4:    ctl_d.eon = 1'b0;
                            3'd5:    ctl_d.non = 1'b0;
                            default: ;
                        endcase
                    end
                    OP_CLEAR: ctl_d.clr = 1'b1;
                    default: ;
                endcase
            end
            S_PH2: begin
                if (op_d == OP_MEM_WR) begin
                    ddata_d   = dat_d;
                    ctl_d.don = 1'b0;
                    ctl_d.ri  = 1'b1;
                end else if (op_d == OP_MEM_RD) begin
                    ctl_d.ron = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign host.CMD_READY = cmd_ready_q;
    assign host.RSP_VALID = rsp_valid_q;
    assign host.RSP_DATA  = rdata_q;
    assign host.RSP_ERR   = err_q;
    assign ATTACHED       = att_q;
    assign DEBUG_REQUEST  = req_q;
    assign DEBUG_DATA     = ddata_q;
    assign {D_CLR, D_HLT, D_CE, D_SU, D_RI,
            D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn,
            D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn} = ctl_q;

endmodule

// File: doc/debug_master.md
Name: debug_master

Overview:
- Host-side driver for the CPU core's debug port.
- Accepts simple commands on a valid/ready interface, raises DEBUG_REQUEST and waits for DEBUG_ACK.
- While attached, sequences the D_* control word and DEBUG_DATA to read and write RAM and registers over the core BUS.
- Returns exactly one response per command. Sits between the host/UART command layer and the core.

Parameters:
- ADDR_W, 4: RAM address width (low bits of CMD_ARG).
- ACK_TIMEOUT, 64: cycles to wait for DEBUG_ACK before reporting an error.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted on CLK edge when CMD_VALID & CMD_READY.
- CMD_OP  in  3  opcode.
- CMD_ARG  in  8  address/register select.
- CMD_DATA  in  8  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed.
- RSP_DATA  out  8  read data; 0 for non-reads.
- RSP_ERR  out  1  command failed.
- ATTACHED  out  1  core is in debug mode under our control.
- DEBUG_REQUEST  out  1  to core.
- DEBUG_ACK  in  1  from core.
- DEBUG_DATA  out  8  value driven onto BUS when D_DOn=0.
- D_CLR, D_HLT, D_CE, D_SU, D_RI  out  1 each  active-high controls.
- D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn  out  1 each  active-low controls.
- BUS  in  8  core bus, sampled for reads.

Behaviour:
- Reset (async) state:
  - State IDLE; DEBUG_REQUEST=0, ATTACHED=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, DEBUG_DATA=0.
  - All active-high D_* = 0; all active-low D_* = 1 (the idle control word).
- All outputs are registered. D_* and DEBUG_DATA hold the idle word in every state except PH1/PH2.
- CMD_READY=1 only in IDLE and READY with no pending response.
- States: IDLE, REQ, READY, PH1, PH2, RSP, REL.
  - IDLE -> REQ on ATTACH.
  - REQ holds DEBUG_REQUEST=1. Goes to RSP(ok) and sets ATTACHED when DEBUG_ACK=1. Goes to RSP(ERR) after ACK_TIMEOUT cycles, dropping the request.
  - READY -> PH1 for RAM/register ops.
  - REL drops DEBUG_REQUEST and waits for DEBUG_ACK=0 (max ACK_TIMEOUT cycles, else ERR), clears ATTACHED, then goes to RSP.
  - RSP holds RSP_VALID until RSP_READY. It then returns to READY if ATTACHED, else IDLE.
- Opcodes:
  - 0 ATTACH. If already attached, immediate ok response.
  - 1 DETACH. If already detached, immediate ok response.
  - 2 MEM_WR:
    - PH1: DEBUG_DATA=ARG[ADDR_W-1:0] zero-extended, D_DOn=0, D_MIn=0.
    - PH2: DEBUG_DATA=CMD_DATA, D_DOn=0, D_RI=1.
  - 3 MEM_RD:
    - PH1 as MEM_WR.
    - PH2: D_ROn=0; BUS captured into RSP_DATA at the PH2-ending edge.
  - 4 REG_WR, single phase, DEBUG_DATA=CMD_DATA, D_DOn=0, plus ARG[2:0] select: 0 D_AIn, 1 D_BIn, 2 D_OIn, 3 D_IIn, 4 D_Jn (PC load); 5–7 -> ERR.
  - 5 REG_RD, single phase, BUS captured, ARG[2:0] select: 0 D_AOn, 1 D_BOn, 2 D_IOn, 3 D_COn, 4 D_EOn, 5 D_NOn; 6–7 -> ERR.
  - 6 CLEAR, single phase: D_CLR=1.
  - 7 reserved -> RSP_ERR=1, no bus activity.
- Latency: accept at edge E0; PH1 drives between E0 and E1; PH2 between E1 and E2. RSP_VALID=1 after E2 (two-phase ops) or after E1 (single-phase ops).
- ERR cases:
  - Ops 2–6 while not ATTACHED: RSP_ERR=1 with no D_* activity.
  - Invalid selects.
  - DEBUG_ACK observed 0 in PH1/PH2: abort immediately, idle word restored, RSP_ERR=1, ATTACHED cleared, DEBUG_REQUEST dropped.
- In READY, DEBUG_ACK falling clears ATTACHED and DEBUG_REQUEST and returns to IDLE, with no response.
- Exactly one D_*Out (DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn) is low in any cycle, or none. This is never violated.
- Async reset mid-operation: immediate idle word, in-flight command dropped with no response.

Test Plan:
- Reset, then ATTACH with a core model that asserts ACK 3 cycles after request -> DEBUG_REQUEST=1 within 1 cycle; RSP ok, ATTACHED=1, RSP_DATA=0.
- MEM_WR ARG=0x0A DATA=0x5C, then MEM_RD ARG=0x0A -> PH1 DEBUG_DATA=0x0A with D_MIn=0; PH2 DEBUG_DATA=0x5C with D_RI=1; read returns RSP_DATA=0x5C, RSP_ERR=0.
- REG_WR ARG=0 DATA=0x81, then REG_RD ARG=0 -> D_AIn low exactly 1 cycle, then D_AOn low 1 cycle; RSP_DATA=0x81.
- ACK never asserted (core model halted) -> RSP_ERR=1 after 64 cycles, DEBUG_REQUEST=0, ATTACHED=0; subsequent MEM_RD -> RSP_ERR=1 with no D_* toggles.
- DEBUG_ACK forced low during PH2 of MEM_RD -> idle word next cycle, RSP_ERR=1, ATTACHED=0.
- Ops and edge cases:
  - REG_RD ARG=7 -> ERR.
  - CMD_OP=7 -> ERR.
  - RSP_READY held low 10 cycles -> RSP_VALID and RSP_DATA stable, CMD_READY=0 throughout.
  - RESETn pulsed mid MEM_WR -> all outputs at reset values asynchronously.
